// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core datapath: SRAM bridge states and
// the data-memory base address.
package arm_pkg;

    typedef enum logic [1:0] {
        SRAM_IDLE,
        SRAM_LOW,
        SRAM_HIGH,
        SRAM_DONE
    } sram_state_t;

    localparam logic [31:0] DATA_MEM_BASE = 32'd1024;

endpackage

// File: rtl/sram_word_ctrl.sv
// Splits a 32-bit data-memory access into two 16-bit asynchronous SRAM
// cycles (low half, then high half) and freezes the pipeline via ready.
module sram_word_ctrl
    import arm_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = DATA_MEM_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    // Word index relative to the memory base; wraps modulo 128K words.
    function automatic logic [16:0] word_index(input logic [31:0] byte_addr);
        return 17'((byte_addr - BASE_ADDR) >> 2);
    endfunction

    sram_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] widx_q, widx_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        request;
    logic        phase_end;
    logic        dq_oe;
    logic [15:0] dq_out;

    assign request   = rd_en | wr_en;
    assign phase_end = (cnt_q == 4'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SRAM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each half-word phase lasts ACCESS_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SRAM_IDLE: if (request)   state_d = SRAM_LOW;
            SRAM_LOW:  if (phase_end) state_d = SRAM_HIGH;
            SRAM_HIGH: if (phase_end) state_d = SRAM_DONE;
            SRAM_DONE:                state_d = SRAM_IDLE;
            default:                  state_d = SRAM_IDLE;
        endcase
    end

    // Phase counter, request latch and read-data capture.
    always_comb begin
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        if ((state_d == SRAM_LOW || state_d == SRAM_HIGH) && state_d != state_q) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (state_q == SRAM_IDLE && request) begin
            widx_d  = word_index(address);
            wdata_d = write_data;
            is_wr_d = wr_en;
        end
        if (!is_wr_q && phase_end) begin
            if (state_q == SRAM_LOW)  rdata_d[15:0]  = SRAM_DQ;
            if (state_q == SRAM_HIGH) rdata_d[31:16] = SRAM_DQ;
        end
    end

    // Control flops and the architecturally visible read_data are reset;
    // the latched request copies are only meaningful once LOW is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            is_wr_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
        end
        widx_q  <= widx_d;
        wdata_q <= wdata_d;
    end

    // Output decode: ready, SRAM address, write strobe and bus drive.
    always_comb begin
        ready     = !(state_q == SRAM_IDLE && request)
                    && state_q != SRAM_LOW && state_q != SRAM_HIGH;
        SRAM_ADDR = 18'd0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = wdata_q[15:0];
        if (state_q == SRAM_LOW) begin
            SRAM_ADDR = {widx_q, 1'b0};
            SRAM_WE_N = !is_wr_q;
            dq_oe     = is_wr_q;
        end else if (state_q == SRAM_HIGH) begin
            SRAM_ADDR = {widx_q, 1'b1};
            SRAM_WE_N = !is_wr_q;
            dq_oe     = is_wr_q;
            dq_out    = wdata_q[31:16];
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign read_data = rdata_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: two instances (ACCESS_CYCLES 2 and 1), each
// attached to a behavioural 256K x 16 asynchronous SRAM model.
module tb_sram_word_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: default ACCESS_CYCLES = 2
    logic        rd0 = 0, wr0 = 0;
    logic [31:0] addr0 = 0, wd0 = 0;
    logic [31:0] rdata0;
    logic        ready0, we0, ub0, lb0, ce0, oe0;
    logic [17:0] a0;
    wire  [15:0] dq0;

    // Instance 1: ACCESS_CYCLES = 1
    logic        rd1 = 0, wr1 = 0;
    logic [31:0] addr1 = 0, wd1 = 0;
    logic [31:0] rdata1;
    logic        ready1, we1, ub1, lb1, ce1, oe1;
    logic [17:0] a1;
    wire  [15:0] dq1;

    sram_word_ctrl #(.ACCESS_CYCLES(2), .BASE_ADDR(32'd1024)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr0),
        .write_data(wd0), .read_data(rdata0), .ready(ready0), .SRAM_DQ(dq0),
        .SRAM_ADDR(a0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_WE_N(we0),
        .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
    );

    sram_word_ctrl #(.ACCESS_CYCLES(1), .BASE_ADDR(32'd1024)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
        .write_data(wd1), .read_data(rdata1), .ready(ready1), .SRAM_DQ(dq1),
        .SRAM_ADDR(a1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_WE_N(we1),
        .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
    );

    // SRAM models: asynchronous read while WE_N is high; a write lands once
    // WE_N has been held low at one address for the full access time.
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];
    int          wcnt0 = 0, wcnt1 = 0;
    logic [17:0] last0 = 0, last1 = 0;

    assign dq0 = we0 ? mem0[a0] : 16'hzzzz;
    assign dq1 = we1 ? mem1[a1] : 16'hzzzz;

    always @(posedge clk) begin
        if (!we0) begin
            int n;
            n = (a0 == last0 && wcnt0 != 0) ? wcnt0 + 1 : 1;
            if (n == 2) mem0[a0] <= dq0;
            wcnt0 <= n;
            last0 <= a0;
        end else begin
            wcnt0 <= 0;
        end
    end

    always @(posedge clk) begin
        if (!we1) begin
            mem1[a1] <= dq1;
            wcnt1    <= 1;
            last1    <= a1;
        end else begin
            wcnt1 <= 0;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_low;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        int          low;
    } exp_t;

    exp_t sb[$];

    // Drives one request at a negedge, counts low-ready cycles until ready
    // returns, and reports read_data from that completion cycle.
    task automatic run_access(input bit sel, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input bit rel, output int low, output logic [31:0] rdata);
        logic r;
        int   guard;
        @(negedge clk);
        if (sel) begin rd1 = rd; wr1 = wr; addr1 = addr; wd1 = wdata; end
        else     begin rd0 = rd; wr0 = wr; addr0 = addr; wd0 = wdata; end
        low = 0;
        guard = 0;
        #1;
        r = sel ? ready1 : ready0;
        while (!r && guard < 50) begin
            low++;
            guard++;
            @(negedge clk);
            #1;
            r = sel ? ready1 : ready0;
        end
        if (!r) low = -1;
        rdata = sel ? rdata1 : rdata0;
        if (rel) begin
            if (sel) begin rd1 = 0; wr1 = 0; end
            else     begin rd0 = 0; wr0 = 0; end
        end
    endtask

    task automatic sb_check(input string name, input int low, input logic [31:0] rdata);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        chk({name, "_ready_low"}, low, e.low);
        chk({name, "_rdata"}, rdata, e.rdata);
    endtask

    vec_t        vecs[5];
    int          low;
    logic [31:0] rdata;

    initial begin
        mem0[0] = 16'h0BAD; mem0[1] = 16'hF00D;
        mem0[4] = 16'h4444; mem0[5] = 16'h3333;
        mem0[13] = 16'h1111;

        vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h00000000, 5};
        vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF, 5};
        vecs[2] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hF00D0BAD, 5};
        vecs[3] = '{1'b0, 1'b1, 32'd525312, 32'h13572468, 32'hF00D0BAD, 5};
        vecs[4] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h13572468, 5};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("idle_ready", {31'd0, ready0}, 32'd1);
            chk("idle_we_n", {31'd0, we0}, 32'd1);
            chk("idle_rdata", rdata0, 32'd0);
        end
        chk("idle_sram_addr", {14'd0, a0}, 32'd0);

        // Table-driven accesses
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{vecs[i].exp_rdata, vecs[i].exp_low});
            run_access(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b1, low, rdata);
            sb_check($sformatf("vec%0d", i), low, rdata);
        end
        chk("mem_2", {16'd0, mem0[2]}, 32'h0000BEEF);
        chk("mem_3", {16'd0, mem0[3]}, 32'h0000DEAD);
        chk("wrap_mem_0", {16'd0, mem0[0]}, 32'h00002468);
        chk("wrap_mem_1", {16'd0, mem0[1]}, 32'h00001357);

        // Back-to-back reads with the request held across DONE
        sb.push_back('{32'h13572468, 5});
        run_access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, low, rdata);
        sb_check("b2b_first", low, rdata);
        sb.push_back('{32'h33334444, 5});
        run_access(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, low, rdata);
        sb_check("b2b_second", low, rdata);

        // Read and write together behave as a write
        sb.push_back('{32'h33334444, 5});
        run_access(1'b0, 1'b1, 1'b1, 32'd1040, 32'h12345678, 1'b1, low, rdata);
        sb_check("rdwr", low, rdata);
        chk("rdwr_mem_8", {16'd0, mem0[8]}, 32'h00005678);
        chk("rdwr_mem_9", {16'd0, mem0[9]}, 32'h00001234);

        // Reset landing at the start of the second HIGH cycle of a write
        @(negedge clk);
        wr0 = 1; addr0 = 32'd1048; wd0 = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wr0 = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ready0}, 32'd1);
        chk("rst_we_n", {31'd0, we0}, 32'd1);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_sram_addr", {14'd0, a0}, 32'd0);
        chk("rst_dq_released", {16'd0, dq0}, 32'h00002468);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stays_idle", {31'd0, ready0 & we0}, 32'd1);
        chk("rst_mem_low", {16'd0, mem0[12]}, 32'h0000F00D);
        chk("rst_mem_high", {16'd0, mem0[13]}, 32'h00001111);

        // ACCESS_CYCLES = 1
        sb.push_back('{32'h00000000, 3});
        run_access(1'b1, 1'b0, 1'b1, 32'd1028, 32'hA1B2C3D4, 1'b1, low, rdata);
        sb_check("a1_write", low, rdata);
        sb.push_back('{32'hA1B2C3D4, 3});
        run_access(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, low, rdata);
        sb_check("a1_read", low, rdata);
        chk("a1_mem_2", {16'd0, mem1[2]}, 32'h0000C3D4);
        chk("a1_mem_3", {16'd0, mem1[3]}, 32'h0000A1B2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
